key_debounce: RTL and testbench

//   Debounces and conditions raw board push-buttons before they reach the Nios PIO

---
 rtl/key_debounce.sv | 211 +++++++++++++++++++++
 tb/tb_key_debounce.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : Push-button conditioning for the Nios PIO key input.
//               Each key is handled on its own. The raw pin passes through a
//               2-flop synchroniser, then a counter-qualified FSM filters
//               contact bounce. Outputs are a clean active-low level and
//               one-cycle press/release pulses.
//               Optional build macro: KEY_LONG_PRESS_EN. When it is defined,
//               each key also gets a hold counter and a one-shot long-press
//               pulse.
// Ports       : clk_50        board clock, rising edge
//               reset_reset_n asynchronous active-low reset
//               key_in        raw key pins, active-low, asynchronous
//               key_out       debounced level, active-low
//               key_press     1-cycle pulse when key_out falls
//               key_release   1-cycle pulse when key_out rises
//               key_long      1-cycle pulse after a long hold (0 when disabled)
// Revision    : 1.0  initial release
// ============================================================================
module key_debounce #(
    parameter int KEY_W           = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic             clk_50,
    input  logic             reset_reset_n,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] key_out,
    output logic [KEY_W-1:0] key_press,
    output logic [KEY_W-1:0] key_release,
    output logic [KEY_W-1:0] key_long
);

    localparam int                c_CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    // A one-cycle window qualifies on the first opposite sample, so the
    // check states are skipped entirely.
    localparam bit                c_ONE_CYCLE = (DEBOUNCE_CYCLES == 1);

    localparam logic [1:0] c_IDLE        = 2'd0;
    localparam logic [1:0] c_PRESS_CHK   = 2'd1;
    localparam logic [1:0] c_PRESSED     = 2'd2;
    localparam logic [1:0] c_RELEASE_CHK = 2'd3;

    if (DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_param_check
        $error("key_debounce: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 1");
    end

    // Two-flop synchroniser. The first stage feeds nothing but the second.
    logic [KEY_W-1:0] r_sync1;
    logic [KEY_W-1:0] r_sync2;

    always_ff @(posedge clk_50 or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= key_in;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar i = 0; i < KEY_W; i++) begin : g_key
        logic               w_key_s;
        logic [1:0]         r_state;
        logic [1:0]         w_state_nxt;
        logic [c_CNT_W-1:0] r_cnt;
        logic [c_CNT_W-1:0] w_cnt_nxt;
        logic               w_press_nxt;
        logic               w_release_nxt;
        logic               r_out;
        logic               r_press;
        logic               r_release;

        assign w_key_s = r_sync2[i];

        always_comb begin
            w_state_nxt   = r_state;
            w_cnt_nxt     = r_cnt;
            w_press_nxt   = 1'b0;
            w_release_nxt = 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (!w_key_s) begin
                        if (c_ONE_CYCLE) begin
                            w_state_nxt = c_PRESSED;
                            w_cnt_nxt   = '0;
                            w_press_nxt = 1'b1;
                        end else begin
                            w_state_nxt = c_PRESS_CHK;
                            w_cnt_nxt   = c_CNT_ONE;
                        end
                    end
                end
                c_PRESS_CHK: begin
                    if (w_key_s) begin
                        // Bounce: drop back and restart the full window later.
                        w_state_nxt = c_IDLE;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt = c_PRESSED;
                        w_cnt_nxt   = '0;
                        w_press_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
                c_PRESSED: begin
                    if (w_key_s) begin
                        if (c_ONE_CYCLE) begin
                            w_state_nxt   = c_IDLE;
                            w_cnt_nxt     = '0;
                            w_release_nxt = 1'b1;
                        end else begin
                            w_state_nxt = c_RELEASE_CHK;
                            w_cnt_nxt   = c_CNT_ONE;
                        end
                    end
                end
                c_RELEASE_CHK: begin
                    if (!w_key_s) begin
                        w_state_nxt = c_PRESSED;
                        w_cnt_nxt   = '0;
                    end else if (r_cnt == c_CNT_LAST) begin
                        w_state_nxt   = c_IDLE;
                        w_cnt_nxt     = '0;
                        w_release_nxt = 1'b1;
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end
                default: begin
                    w_state_nxt = c_IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end

        // The level is registered from the next state so that it changes on
        // the same edge as the pulses.
        always_ff @(posedge clk_50 or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                r_state   <= c_IDLE;
                r_cnt     <= '0;
                r_out     <= 1'b1;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_state   <= w_state_nxt;
                r_cnt     <= w_cnt_nxt;
                r_out     <= (w_state_nxt == c_IDLE) || (w_state_nxt == c_PRESS_CHK);
                r_press   <= w_press_nxt;
                r_release <= w_release_nxt;
            end
        end

        assign key_out[i]     = r_out;
        assign key_press[i]   = r_press;
        assign key_release[i] = r_release;

`ifdef KEY_LONG_PRESS_EN
        localparam int                 c_HCNT_W    = $clog2(LONG_CYCLES + 1);
        localparam logic [c_HCNT_W-1:0] c_HCNT_MAX  = c_HCNT_W'(LONG_CYCLES);
        localparam logic [c_HCNT_W-1:0] c_HCNT_LAST = c_HCNT_W'(LONG_CYCLES - 1);

        logic [c_HCNT_W-1:0] r_hcnt;
        logic [c_HCNT_W-1:0] w_hcnt_nxt;
        logic                w_long_nxt;
        logic                r_long;
        logic                w_held;

        // Held means the key stays down across this edge. A release check
        // that is aborted keeps counting; leaving to IDLE clears the count.
        // While released the counter sits at 0, so PRESSED entry starts at 0.
        assign w_held = ((r_state == c_PRESSED) || (r_state == c_RELEASE_CHK)) &&
                        (w_state_nxt != c_IDLE);

        always_comb begin
            w_hcnt_nxt = '0;
            w_long_nxt = 1'b0;
            if (w_held) begin
                w_hcnt_nxt = r_hcnt;
                if (r_hcnt != c_HCNT_MAX) begin
                    w_hcnt_nxt = r_hcnt + c_HCNT_W'(1);
                    // Fires only on the step onto the saturation value,
                    // so it cannot repeat while the key stays held.
                    w_long_nxt = (r_hcnt == c_HCNT_LAST);
                end
            end
        end

        always_ff @(posedge clk_50 or negedge reset_reset_n) begin
            if (!reset_reset_n) begin
                r_hcnt <= '0;
                r_long <= 1'b0;
            end else begin
                r_hcnt <= w_hcnt_nxt;
                r_long <= w_long_nxt;
            end
        end

        assign key_long[i] = r_long;
`else
        assign key_long[i] = 1'b0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_debounce
// Description : Self-checking bench for key_debounce (KEY_W=2,
//               DEBOUNCE_CYCLES=8, LONG_CYCLES=32). A reference model tracks
//               the last DEBOUNCE_CYCLES synchronised samples per key and the
//               hold time since each press. It is compared with the DUT every
//               cycle, alongside fixed-edge checks. Honours KEY_LONG_PRESS_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_key_debounce;

    localparam int KEY_W = 2;
    localparam int DEB   = 8;
    localparam int LONG  = 32;

    logic             clk_50 = 1'b0;
    logic             reset_reset_n;
    logic [KEY_W-1:0] key_in;
    logic [KEY_W-1:0] key_out;
    logic [KEY_W-1:0] key_press;
    logic [KEY_W-1:0] key_release;
    logic [KEY_W-1:0] key_long;

    int n_checks = 0;
    int n_errors = 0;

    key_debounce #(
        .KEY_W           (KEY_W),
        .DEBOUNCE_CYCLES (DEB),
        .LONG_CYCLES     (LONG)
    ) dut (
        .clk_50        (clk_50),
        .reset_reset_n (reset_reset_n),
        .key_in        (key_in),
        .key_out       (key_out),
        .key_press     (key_press),
        .key_release   (key_release),
        .key_long      (key_long)
    );

    always #10 clk_50 = ~clk_50;

    // ---------------- reference model ----------------
    logic [KEY_W-1:0] m_out, m_press, m_release, m_long;
    logic [KEY_W-1:0] in_q[$];   // raw samples still inside the synchroniser
    logic [KEY_W-1:0] win_q[$];  // most recent DEB synchronised samples
    int               m_hold[KEY_W];

    always @(posedge clk_50 or negedge reset_reset_n) begin : model
        logic [KEY_W-1:0] ks;
        logic             was;
        logic             all_opp;
        if (!reset_reset_n) begin
            m_out     = '1;
            m_press   = '0;
            m_release = '0;
            m_long    = '0;
            in_q      = {};
            in_q.push_back('1);
            in_q.push_back('1);
            win_q     = {};
            for (int k = 0; k < KEY_W; k++) m_hold[k] = 0;
        end else begin
            ks = in_q.pop_front();
            in_q.push_back(key_in);
            win_q.push_back(ks);
            if (win_q.size() > DEB) void'(win_q.pop_front());
            m_press   = '0;
            m_release = '0;
            m_long    = '0;
            for (int k = 0; k < KEY_W; k++) begin
                was = m_out[k];
                if (win_q.size() == DEB) begin
                    all_opp = 1'b1;
                    foreach (win_q[j]) if (win_q[j][k] == was) all_opp = 1'b0;
                    if (all_opp) begin
                        m_out[k] = ~was;
                        if (was) m_press[k] = 1'b1;
                        else     m_release[k] = 1'b1;
                    end
                end
                if (!was && !m_out[k]) begin
                    if (m_hold[k] < LONG) begin
                        m_hold[k]++;
`ifdef KEY_LONG_PRESS_EN
                        if (m_hold[k] == LONG) m_long[k] = 1'b1;
`endif
                    end
                end else begin
                    m_hold[k] = 0;
                end
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        key_in        = 2'b11;
        reset_reset_n = 1'b1;
        #1 reset_reset_n = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            @(negedge clk_50);
            n_checks++;
            if ({key_out, key_press, key_release, key_long} !== {2'b11, 6'b0}) begin
                n_errors++;
                $display("FAIL reset_state cyc %0d: got out=%b p=%b r=%b l=%b, expected out=11 p=00 r=00 l=00",
                         e, key_out, key_press, key_release, key_long);
            end
        end
        reset_reset_n = 1'b1;
    endtask

    task automatic test_press();
        key_in = 2'b10;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk_50);
            n_checks++;
            if ({key_out, key_press, key_release, key_long} !== {m_out, m_press, m_release, m_long}) begin
                n_errors++;
                $display("FAIL press_model edge %0d: got %b/%b/%b/%b, expected %b/%b/%b/%b", e,
                         key_out, key_press, key_release, key_long, m_out, m_press, m_release, m_long);
            end
            if (e == 9) begin
                n_checks++;
                if (key_out !== 2'b11) begin
                    n_errors++;
                    $display("FAIL press_early edge 9: key_out=%b, expected 11", key_out);
                end
            end
            if (e == 10) begin
                n_checks++;
                if (key_out !== 2'b10 || key_press !== 2'b01) begin
                    n_errors++;
                    $display("FAIL press_edge10: key_out=%b key_press=%b, expected 10/01", key_out, key_press);
                end
            end
            if (e == 11) begin
                n_checks++;
                if (key_press !== 2'b00 || key_out !== 2'b10) begin
                    n_errors++;
                    $display("FAIL press_one_cycle: key_press=%b key_out=%b, expected 00/10", key_press, key_out);
                end
            end
        end
    endtask

    task automatic test_release();
        key_in = 2'b11;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk_50);
            n_checks++;
            if ({key_out, key_press, key_release, key_long} !== {m_out, m_press, m_release, m_long}) begin
                n_errors++;
                $display("FAIL release_model edge %0d: got %b/%b/%b/%b, expected %b/%b/%b/%b", e,
                         key_out, key_press, key_release, key_long, m_out, m_press, m_release, m_long);
            end
            if (e == 9) begin
                n_checks++;
                if (key_out !== 2'b10 || key_release !== 2'b00) begin
                    n_errors++;
                    $display("FAIL release_early edge 9: key_out=%b key_release=%b, expected 10/00", key_out, key_release);
                end
            end
            if (e == 10) begin
                n_checks++;
                if (key_out !== 2'b11 || key_release !== 2'b01) begin
                    n_errors++;
                    $display("FAIL release_edge10: key_out=%b key_release=%b, expected 11/01", key_out, key_release);
                end
            end
        end
    endtask

    task automatic test_bounce();
        // 5 low, 2 high, then held low; then released for clean-up
        for (int e = 1; e <= 36; e++) begin
            key_in = (e <= 5 || (e >= 8 && e <= 24)) ? 2'b10 : 2'b11;
            @(negedge clk_50);
            n_checks++;
            if ({key_out, key_press, key_release, key_long} !== {m_out, m_press, m_release, m_long}) begin
                n_errors++;
                $display("FAIL bounce_model step %0d: got %b/%b/%b/%b, expected %b/%b/%b/%b", e,
                         key_out, key_press, key_release, key_long, m_out, m_press, m_release, m_long);
            end
            if (e <= 16) begin
                n_checks++;
                if (key_press !== 2'b00 || key_out !== 2'b11) begin
                    n_errors++;
                    $display("FAIL bounce_no_pulse step %0d: key_press=%b key_out=%b, expected 00/11", e, key_press, key_out);
                end
            end
            if (e == 17) begin
                n_checks++;
                if (key_press !== 2'b01 || key_out !== 2'b10) begin
                    n_errors++;
                    $display("FAIL bounce_final_fall: key_press=%b key_out=%b, expected 01/10", key_press, key_out);
                end
            end
        end
    endtask

    task automatic test_simultaneous_reset();
        key_in = 2'b00;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk_50);
            n_checks++;
            if ({key_out, key_press, key_release, key_long} !== {m_out, m_press, m_release, m_long}) begin
                n_errors++;
                $display("FAIL simul_model edge %0d: got %b/%b/%b/%b, expected %b/%b/%b/%b", e,
                         key_out, key_press, key_release, key_long, m_out, m_press, m_release, m_long);
            end
            if (e == 10) begin
                n_checks++;
                if (key_press !== 2'b11 || key_out !== 2'b00) begin
                    n_errors++;
                    $display("FAIL simul_press: key_press=%b key_out=%b, expected 11/00", key_press, key_out);
                end
            end
        end
        key_in = 2'b11;
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk_50);
            n_checks++;
            if ({key_out, key_press, key_release, key_long} !== {m_out, m_press, m_release, m_long}) begin
                n_errors++;
                $display("FAIL relchk_model edge %0d: got %b/%b/%b/%b, expected %b/%b/%b/%b", e,
                         key_out, key_press, key_release, key_long, m_out, m_press, m_release, m_long);
            end
        end
        // Mid release check: reset must clear without waiting for a clock edge.
        #2 reset_reset_n = 1'b0;
        key_in = 2'b00;
        #1;
        n_checks++;
        if ({key_out, key_press, key_release, key_long} !== {2'b11, 6'b0}) begin
            n_errors++;
            $display("FAIL async_reset: got out=%b p=%b r=%b l=%b, expected 11/00/00/00",
                     key_out, key_press, key_release, key_long);
        end
        @(negedge clk_50);
        @(negedge clk_50);
        reset_reset_n = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            @(negedge clk_50);
            n_checks++;
            if ({key_out, key_press, key_release, key_long} !== {m_out, m_press, m_release, m_long}) begin
                n_errors++;
                $display("FAIL repress_model edge %0d: got %b/%b/%b/%b, expected %b/%b/%b/%b", e,
                         key_out, key_press, key_release, key_long, m_out, m_press, m_release, m_long);
            end
            if (e == 10) begin
                n_checks++;
                if (key_press !== 2'b11 || key_out !== 2'b00) begin
                    n_errors++;
                    $display("FAIL repress_after_reset: key_press=%b key_out=%b, expected 11/00", key_press, key_out);
                end
            end
        end
    endtask

    task automatic test_long();
        logic [KEY_W-1:0] exp_long;
`ifdef KEY_LONG_PRESS_EN
        exp_long = 2'b10;
`else
        exp_long = 2'b00;
`endif
        key_in = 2'b11;
        for (int e = 1; e <= 14; e++) begin
            @(negedge clk_50);
            n_checks++;
            if ({key_out, key_press, key_release, key_long} !== {m_out, m_press, m_release, m_long}) begin
                n_errors++;
                $display("FAIL long_pre_model edge %0d: got %b/%b/%b/%b, expected %b/%b/%b/%b", e,
                         key_out, key_press, key_release, key_long, m_out, m_press, m_release, m_long);
            end
        end
        key_in = 2'b01;
        for (int e = 1; e <= 64; e++) begin
            @(negedge clk_50);
            n_checks++;
            if ({key_out, key_press, key_release, key_long} !== {m_out, m_press, m_release, m_long}) begin
                n_errors++;
                $display("FAIL long_model edge %0d: got %b/%b/%b/%b, expected %b/%b/%b/%b", e,
                         key_out, key_press, key_release, key_long, m_out, m_press, m_release, m_long);
            end
            if (e == 42) begin
                n_checks++;
                if (key_long !== exp_long || key_out !== 2'b01) begin
                    n_errors++;
                    $display("FAIL long_pulse edge 42: key_long=%b key_out=%b, expected %b/01", key_long, key_out, exp_long);
                end
            end else begin
                n_checks++;
                if (key_long !== 2'b00) begin
                    n_errors++;
                    $display("FAIL long_quiet edge %0d: key_long=%b, expected 00", e, key_long);
                end
            end
        end
        key_in = 2'b11;
        for (int e = 1; e <= 14; e++) begin
            @(negedge clk_50);
            n_checks++;
            if ({key_out, key_press, key_release, key_long} !== {m_out, m_press, m_release, m_long}) begin
                n_errors++;
                $display("FAIL long_post_model edge %0d: got %b/%b/%b/%b, expected %b/%b/%b/%b", e,
                         key_out, key_press, key_release, key_long, m_out, m_press, m_release, m_long);
            end
        end
    endtask

    task automatic test_random();
        int hold;
        for (int s = 0; s < 60; s++) begin
            key_in = KEY_W'($urandom_range(0, 3));
            hold   = (s % 4 == 3) ? int'($urandom_range(40, 50)) : int'($urandom_range(1, 12));
            for (int c = 0; c < hold; c++) begin
                @(negedge clk_50);
                n_checks++;
                if ({key_out, key_press, key_release, key_long} !== {m_out, m_press, m_release, m_long}) begin
                    n_errors++;
                    $display("FAIL random_model seg %0d cyc %0d: got %b/%b/%b/%b, expected %b/%b/%b/%b", s, c,
                             key_out, key_press, key_release, key_long, m_out, m_press, m_release, m_long);
                end
                n_checks++;
                if ((key_press & key_release) !== 2'b00) begin
                    n_errors++;
                    $display("FAIL random_pulse_overlap seg %0d: press=%b release=%b, expected disjoint", s, key_press, key_release);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_simultaneous_reset();
        test_long();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
